rgb_sequencer: RTL and testbench
================================

Name: rgb_sequencer

Overview:
- Timed sequencer that steps the one-hot color code through RED (3'b001), GREEN (3'b010), BLUE (3'b100), then repeats.
- Each color is held for a programmable dwell time.
- Drives the color-select input of the RGB one-hot color datapath: LED/display driver or test pattern source.
- Supports start, stop, hold, a finite or infinite number of full cycles, and per-color skip.

Parameters:
CNT_W, 8, width of dwell timers and dwell inputs
CYC_W, 8, width of cycle counter and num_cycles input

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  begin sequence (sampled in IDLE only)
stop  input  1  abort sequence, return to IDLE
hold  input  1  freeze sequence (level)
dwell_r  input  CNT_W  RED dwell in cycles, 0 = skip RED
dwell_g  input  CNT_W  GREEN dwell in cycles, 0 = skip GREEN
dwell_b  input  CNT_W  BLUE dwell in cycles, 0 = skip BLUE
num_cycles  input  CYC_W  full RGB passes to run, 0 = run forever
color  output  3  one-hot color: 001 RED, 010 GREEN, 100 BLUE, 000 off
busy  output  1  high in any non-IDLE state
done  output  1  one-cycle pulse on normal completion
err  output  1  one-cycle pulse when start is rejected
cycle_cnt  output  CYC_W  completed full passes in the current run

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, color=000, busy=0, done=0, err=0, cycle_cnt=0, timer=0.
  - Latched dwell and num_cycles values are cleared to 0.
- States: IDLE, RED, GREEN, BLUE; color is a registered decode of state (IDLE -> 000).
- Start from IDLE:
  - start=1 with at least one nonzero dwell: latch dwell_r/g/b and num_cycles, clear cycle_cnt.
  - Go to the first color in order R, G, B whose latched dwell is nonzero; load timer = dwell-1.
  - color is valid on the edge after start is sampled (latency 1).
- Start rejected: start=1 with all dwells 0 -> stay IDLE, err=1 for one cycle.
- start is ignored outside IDLE.
- Dwell: a color state with dwell D asserts color for exactly D consecutive clocks (hold excluded).
  - The timer decrements each non-held cycle.
  - At timer==0, move to the next nonzero-dwell color in R->G->B->R order and load its timer.
  - Zero-dwell colors are skipped with no gap cycle.
- Pass completion: leaving the last nonzero-dwell color of a pass (the wrap back toward R) increments cycle_cnt.
  - If num_cycles!=0 and the incremented value equals num_cycles: go to IDLE, color=000, done=1 for one cycle.
  - cycle_cnt keeps its final value until the next accepted start.
- Infinite mode (num_cycles=0): cycle_cnt wraps modulo 2^CYC_W and the sequence never completes.
- Single-color run: only one nonzero dwell -> that color stays asserted continuously across passes, with no glitch. cycle_cnt increments every D cycles.
- hold=1 in a color state: state, timer and cycle_cnt freeze and color stays unchanged.
  - Release resumes with the remaining dwell.
  - hold has no effect in IDLE.
- stop=1 in any non-IDLE state: next edge -> IDLE, color=000, done=0. cycle_cnt is retained.
- Priority on the same cycle: stop > hold > timer expiry. stop beats start in IDLE, so start is ignored there.
- Dwell input changes during a run have no effect; latched values are used until the next start.
- Async reset mid-run forces the reset values immediately. There is no done pulse.
- done and err are never asserted together. busy falls on the same edge that done rises.

Test Plan:
- Basic run: dwell_r=3, dwell_g=2, dwell_b=1, num_cycles=2, start pulse -> color 001x3, 010x2, 100x1, repeat; cycle_cnt 1 then 2; done pulse after the 12th colored cycle; color=000, busy=0.
- Skip and reject: dwell_r=0, dwell_g=2, dwell_b=0, num_cycles=3 -> color=010 for 6 consecutive cycles, cycle_cnt increments every 2, then done. All dwells 0 -> err pulse, busy stays 0.
- Hold: dwell_r=4, assert hold for 5 cycles after the 2nd RED cycle -> RED asserted 9 cycles total; timer resumes with 2 remaining.
- Stop and priority: stop in GREEN -> color=000 next cycle, no done. stop+hold asserted together -> IDLE. start+stop together in IDLE -> stays IDLE.
- Infinite and wrap: CYC_W=2, num_cycles=0, all dwells 1 -> cycle_cnt 1,2,3,0,1..., no done; start asserted mid-run is ignored.
- Reset mid-run: drop rst_n asynchronously during BLUE -> color=000, busy=0, cycle_cnt=0 before the next clock edge.

Source files
------------

// File: rtl/rgb_sequencer.sv
// Timed one-hot RED/GREEN/BLUE sequencer with programmable per-color dwell,
// finite or endless pass count, per-color skip, hold and stop.
module rgb_sequencer #(
   parameter int CNT_W = 8,
   parameter int CYC_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             hold,
   input  logic [CNT_W-1:0] dwell_r,
   input  logic [CNT_W-1:0] dwell_g,
   input  logic [CNT_W-1:0] dwell_b,
   input  logic [CYC_W-1:0] num_cycles,
   output logic [2:0]       color,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CYC_W-1:0] cycle_cnt
);

   typedef enum logic [1:0] {IDLE, RED, GREEN, BLUE} state_t;

   state_t           state;
   state_t           next_color;
   state_t           first_color;
   logic [CNT_W-1:0] timer;
   logic [CNT_W-1:0] lat_r;
   logic [CNT_W-1:0] lat_g;
   logic [CNT_W-1:0] lat_b;
   logic [CNT_W-1:0] next_dwell;
   logic [CNT_W-1:0] first_dwell;
   logic [CYC_W-1:0] lat_num;
   logic [CYC_W-1:0] cnt_inc;
   logic             wrap;

   function automatic logic [2:0] decode(input state_t s);
      case (s)
         RED:     return 3'b001;
         GREEN:   return 3'b010;
         BLUE:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   // Next nonzero-dwell color in R->G->B->R order; wrap marks the end of a pass.
   always_comb begin
      next_color = state;
      next_dwell = '0;
      wrap       = 1'b0;
      case (state)
         RED: begin
            if (lat_g != '0) begin
               next_color = GREEN;
               next_dwell = lat_g;
            end else if (lat_b != '0) begin
               next_color = BLUE;
               next_dwell = lat_b;
            end else begin
               next_color = RED;
               next_dwell = lat_r;
               wrap       = 1'b1;
            end
         end
         GREEN: begin
            if (lat_b != '0) begin
               next_color = BLUE;
               next_dwell = lat_b;
            end else if (lat_r != '0) begin
               next_color = RED;
               next_dwell = lat_r;
               wrap       = 1'b1;
            end else begin
               next_color = GREEN;
               next_dwell = lat_g;
               wrap       = 1'b1;
            end
         end
         BLUE: begin
            wrap = 1'b1;
            if (lat_r != '0) begin
               next_color = RED;
               next_dwell = lat_r;
            end else if (lat_g != '0) begin
               next_color = GREEN;
               next_dwell = lat_g;
            end else begin
               next_color = BLUE;
               next_dwell = lat_b;
            end
         end
         default: ;
      endcase
   end

   // First color of a run comes from the live inputs, since they are latched on that same edge.
   always_comb begin
      first_color = IDLE;
      first_dwell = '0;
      if (dwell_r != '0) begin
         first_color = RED;
         first_dwell = dwell_r;
      end else if (dwell_g != '0) begin
         first_color = GREEN;
         first_dwell = dwell_g;
      end else if (dwell_b != '0) begin
         first_color = BLUE;
         first_dwell = dwell_b;
      end
   end

   assign cnt_inc = cycle_cnt + CYC_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         timer     <= '0;
         lat_r     <= '0;
         lat_g     <= '0;
         lat_b     <= '0;
         lat_num   <= '0;
         cycle_cnt <= '0;
         color     <= 3'b000;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (state == IDLE) begin
            if (start && !stop) begin
               if (first_color != IDLE) begin
                  lat_r     <= dwell_r;
                  lat_g     <= dwell_g;
                  lat_b     <= dwell_b;
                  lat_num   <= num_cycles;
                  cycle_cnt <= '0;
                  state     <= first_color;
                  timer     <= first_dwell - CNT_W'(1);
                  color     <= decode(first_color);
                  busy      <= 1'b1;
               end else begin
                  err <= 1'b1;
               end
            end
         end else if (stop) begin
            state <= IDLE;
            color <= 3'b000;
            busy  <= 1'b0;
         end else if (!hold) begin
            if (timer != '0) begin
               timer <= timer - CNT_W'(1);
            end else if (wrap && (lat_num != '0) && (cnt_inc == lat_num)) begin
               cycle_cnt <= cnt_inc;
               state     <= IDLE;
               color     <= 3'b000;
               busy      <= 1'b0;
               done      <= 1'b1;
            end else begin
               if (wrap) cycle_cnt <= cnt_inc;
               state <= next_color;
               timer <= next_dwell - CNT_W'(1);
               color <= decode(next_color);
            end
         end
      end
   end

endmodule

// File: tb/tb_rgb_sequencer.sv
// Scoreboard bench for rgb_sequencer: stimulus queues the expected colored/done/err
// cycles, a negedge monitor pops and compares each one the DUT presents.
module tb_rgb_sequencer;

   localparam int CNT_W = 8;
   localparam int CYC_W = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic             hold = 1'b0;
   logic [CNT_W-1:0] dwell_r = '0;
   logic [CNT_W-1:0] dwell_g = '0;
   logic [CNT_W-1:0] dwell_b = '0;
   logic [CYC_W-1:0] num_cycles = '0;
   logic [2:0]       color;
   logic             busy;
   logic             done;
   logic             err;
   logic [CYC_W-1:0] cycle_cnt;

   typedef struct packed {
      logic [2:0]       color;
      logic             busy;
      logic             done;
      logic             err;
      logic [CYC_W-1:0] cnt;
   } obs_t;

   obs_t expect_q[$];
   obs_t mon_got;
   obs_t mon_exp;
   int   checks = 0;
   int   failures = 0;
   int   events = 0;

   rgb_sequencer #(.CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold),
      .dwell_r(dwell_r), .dwell_g(dwell_g), .dwell_b(dwell_b),
      .num_cycles(num_cycles), .color(color), .busy(busy), .done(done),
      .err(err), .cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   // Every cycle showing a color, done or err must match the oldest queued expectation.
   always @(negedge clk) begin
      if (color != 3'b000 || done || err) begin
         mon_got = obs_t'({color, busy, done, err, cycle_cnt});
         events++;
         checks++;
         if (expect_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL event %0d unexpected: got color=%b busy=%b done=%b err=%b cnt=%0d, expected none",
                     events, color, busy, done, err, cycle_cnt);
         end else begin
            mon_exp = expect_q.pop_front();
            if (mon_got !== mon_exp) begin
               failures++;
               $display("[TB] FAIL event %0d: got color=%b busy=%b done=%b err=%b cnt=%0d, expected color=%b busy=%b done=%b err=%b cnt=%0d",
                        events, mon_got.color, mon_got.busy, mon_got.done, mon_got.err, mon_got.cnt,
                        mon_exp.color, mon_exp.busy, mon_exp.done, mon_exp.err, mon_exp.cnt);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pushRun(input logic [2:0] c, input int n, input logic [CYC_W-1:0] cnt);
      for (int i = 0; i < n; i++) expect_q.push_back(obs_t'({c, 1'b1, 1'b0, 1'b0, cnt}));
   endtask

   task automatic pushDone(input logic [CYC_W-1:0] cnt);
      expect_q.push_back(obs_t'({3'b000, 1'b0, 1'b1, 1'b0, cnt}));
   endtask

   task automatic pushErr(input logic [CYC_W-1:0] cnt);
      expect_q.push_back(obs_t'({3'b000, 1'b0, 1'b0, 1'b1, cnt}));
   endtask

   // Called on a negedge; pulses start for exactly one rising edge.
   task automatic applyStimulus(input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] g,
                                input logic [CNT_W-1:0] b, input logic [CYC_W-1:0] num);
      dwell_r    = r;
      dwell_g    = g;
      dwell_b    = b;
      num_cycles = num;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDrained(input string name);
      for (int i = 0; i < 60 && expect_q.size() != 0; i++) @(negedge clk);
      checkOutput(name, expect_q.size(), 0);
   endtask

   initial begin
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      tick(3);
      checkOutput("reset color", color, 3'b000);
      checkOutput("reset busy", busy, 1'b0);
      checkOutput("reset done", done, 1'b0);
      checkOutput("reset err", err, 1'b0);
      checkOutput("reset cycle_cnt", cycle_cnt, 0);
      rst_n = 1'b1;
      tick(1);

      $display("[TB] basic run 3/2/1 x2");
      pushRun(3'b001, 3, 0); pushRun(3'b010, 2, 0); pushRun(3'b100, 1, 0);
      pushRun(3'b001, 3, 1); pushRun(3'b010, 2, 1); pushRun(3'b100, 1, 1);
      pushDone(2);
      applyStimulus(3, 2, 1, 2);
      waitDrained("basic drained");
      checkOutput("basic busy after done", busy, 1'b0);
      tick(2);
      checkOutput("basic color idle", color, 3'b000);
      checkOutput("basic cycle_cnt kept", cycle_cnt, 2);

      $display("[TB] skip red/blue, then reject");
      pushRun(3'b010, 2, 0); pushRun(3'b010, 2, 1); pushRun(3'b010, 2, 2);
      pushDone(3);
      applyStimulus(0, 2, 0, 3);
      waitDrained("skip drained");
      tick(2);
      pushErr(3);
      applyStimulus(0, 0, 0, 1);
      checkOutput("reject busy", busy, 1'b0);
      tick(1);
      checkOutput("reject busy later", busy, 1'b0);
      waitDrained("reject drained");

      $display("[TB] hold in red");
      pushRun(3'b001, 9, 0);
      pushDone(1);
      applyStimulus(4, 0, 0, 1);
      tick(1);
      hold = 1'b1;
      tick(5);
      hold = 1'b0;
      waitDrained("hold drained");
      tick(2);

      $display("[TB] stop in green of second pass");
      pushRun(3'b001, 2, 0); pushRun(3'b010, 3, 0); pushRun(3'b100, 1, 0);
      pushRun(3'b001, 2, 1); pushRun(3'b010, 1, 1);
      applyStimulus(2, 3, 1, 0);
      tick(8);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      checkOutput("stop color", color, 3'b000);
      checkOutput("stop busy", busy, 1'b0);
      checkOutput("stop cycle_cnt kept", cycle_cnt, 1);
      waitDrained("stop drained");
      tick(3);

      $display("[TB] stop with hold, start with stop");
      pushRun(3'b001, 1, 0);
      applyStimulus(3, 0, 0, 0);
      stop = 1'b1;
      hold = 1'b1;
      tick(1);
      stop = 1'b0;
      hold = 1'b0;
      checkOutput("stop+hold busy", busy, 1'b0);
      waitDrained("stop+hold drained");
      tick(1);
      dwell_r = 3; dwell_g = 3; dwell_b = 3;
      start = 1'b1;
      stop  = 1'b1;
      tick(1);
      start = 1'b0;
      stop  = 1'b0;
      checkOutput("start+stop busy", busy, 1'b0);
      checkOutput("start+stop color", color, 3'b000);
      tick(2);

      $display("[TB] infinite mode with counter wrap");
      for (int k = 0; k < 5; k++) begin
         pushRun(3'b001, 1, CYC_W'(k));
         pushRun(3'b010, 1, CYC_W'(k));
         pushRun(3'b100, 1, CYC_W'(k));
      end
      applyStimulus(1, 1, 1, 0);
      tick(6);
      dwell_r = 5;
      start   = 1'b1;
      tick(1);
      start = 1'b0;
      checkOutput("infinite busy mid-run", busy, 1'b1);
      tick(7);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      checkOutput("infinite cycle_cnt wrapped", cycle_cnt, 0);
      checkOutput("infinite busy after stop", busy, 1'b0);
      waitDrained("infinite drained");
      tick(2);

      $display("[TB] async reset during blue");
      pushRun(3'b001, 1, 0); pushRun(3'b010, 1, 0); pushRun(3'b100, 2, 0);
      pushRun(3'b001, 1, 1); pushRun(3'b010, 1, 1); pushRun(3'b100, 1, 1);
      applyStimulus(1, 1, 2, 0);
      tick(6);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async reset color", color, 3'b000);
      checkOutput("async reset busy", busy, 1'b0);
      checkOutput("async reset cycle_cnt", cycle_cnt, 0);
      checkOutput("async reset done", done, 1'b0);
      waitDrained("reset drained");
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);
      checkOutput("post-reset busy", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
